btn_conditioner: RTL and testbench
==================================

// Module: btn_conditioner
// PURPOSE
//   Front-end conditioning for the calculator's five push-buttons.
//   - Each raw pad input is synchronised to clk, debounced, and presented two ways:
//     a clean level and a one-cycle rising-edge pulse.
//   - Sits directly upstream of the calculator core:
//     - op-select buttons use the level;
//     - accumulate/clear use the pulse, giving exactly one update per physical press.
// PARAMETERS
//   N_BTN      5          number of button channels
//   DB_CYCLES  1_000_000  stable cycles required before a level change is accepted (10 ms @ 100 MHz); >=1
//   RPT_DELAY  50_000_000 cycles from first pulse to first auto-repeat pulse (BTN_AUTOREPEAT_EN only)
//   RPT_PERIOD 10_000_000 cycles between subsequent auto-repeat pulses (BTN_AUTOREPEAT_EN only)
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   resetn     in   1      asynchronous, active-low reset
//   btn_raw    in   N_BTN  raw pad inputs; bit map {btnd,btnr,btnu,btnl,btnc} = [4:0]
//   btn_level  out  N_BTN  debounced level per channel
//   btn_pulse  out  N_BTN  one-cycle high on each accepted press (and on repeats, if enabled)
// BEHAVIOUR
//   - Reset: sync flops, counters, btn_level and btn_pulse all 0; async assert, release sampled on clk.
//   - Per channel, all channels fully independent (simultaneous presses each handled normally):
//     - 2-FF synchroniser on btn_raw -> s.
//     - If s == btn_level: counter cleared to 0.
//     - If s != btn_level:
//       - counter increments each cycle;
//       - when counter == DB_CYCLES-1 with s still differing, btn_level <= s and counter <= 0.
//     - Any return of s to btn_level before acceptance clears counter; glitches < DB_CYCLES cycles are
//       never seen.
//   - Latency: raw edge held steady -> btn_level changes exactly 2+DB_CYCLES cycles later.
//   - btn_pulse: high for exactly the cycle in which btn_level goes 0->1, registered and aligned with
//     btn_level. Release (1->0) produces no pulse.
//   - Counter width = $clog2(DB_CYCLES+1); counter never exceeds DB_CYCLES-1, no wrap.
//   - Reset mid-count discards progress. A button held through reset release reports as a fresh press:
//     level rise plus one pulse after 2+DB_CYCLES cycles.
//   - DB_CYCLES=1: level follows s one cycle after any difference (3-cycle total latency).
// CONFIGURATION
//   BTN_AUTOREPEAT_EN defined:
//     - per-channel repeat counter runs while btn_level==1;
//     - further btn_pulse at RPT_DELAY cycles after the initial pulse, then every RPT_PERIOD cycles;
//     - repeat counter cleared when btn_level falls or on reset; no pulse on release.
//   BTN_AUTOREPEAT_EN undefined: exactly one pulse per accepted press; repeat logic and
//   RPT_* parameters unused.
// STRUCTURE
//   - Package btn_pkg:
//     - BTN_C=0, BTN_L=1, BTN_U=2, BTN_R=3, BTN_D=4;
//     - N_BTN_DEFAULT=5;
//     - function cnt_w(n) returning counter width.
//   - Sub-module btn_debounce_ch: one channel (sync, debounce counter, edge pulse, optional repeat).
//     Top instantiates N_BTN copies via generate.
// TESTING  (run with DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3)
//   1. Reset: resetn=0 with btn_raw=5'b11111 -> btn_level=0, btn_pulse=0 while low.
//      After release, each channel rises at cycle 6 with one pulse.
//   2. Clean press: btn_raw[4] 0->1 held 20 cycles -> btn_level[4] rises 6 cycles later,
//      btn_pulse[4] high exactly 1 cycle. Release -> level falls 6 cycles later, no pulse.
//   3. Bounce: btn_raw[0] toggles 1,0,1,0 every 2 cycles, then held 1 -> no pulse during bouncing,
//      single pulse 6 cycles after the final edge.
//   4. Simultaneous: btn_raw[1] and btn_raw[3] rise same cycle -> both levels and pulses in the
//      same cycle; other bits stay 0.
//   5. Reset mid-count: btn_raw[2]=1, resetn pulsed low at cycle 3 of count -> no pulse before
//      release. After release, pulse at cycle 6 post-release.
//   6. BTN_AUTOREPEAT_EN: hold btn_raw[4] 30 cycles -> pulses at t0, t0+10, t0+13, t0+16, ...
//      Without the macro: only the t0 pulse.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// btn_pkg: shared button indices, default channel count and counter sizing helper.
package btn_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_U = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    localparam int N_BTN_DEFAULT = 5;

    typedef enum logic [2:0] {
        BTN_IDX_C = 3'd0,
        BTN_IDX_L = 3'd1,
        BTN_IDX_U = 3'd2,
        BTN_IDX_R = 3'd3,
        BTN_IDX_D = 3'd4
    } btn_idx_e;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw pad inputs in, debounced level and press pulse out.
interface btn_conditioner_if
    import btn_pkg::*;
#(
    parameter int N = N_BTN_DEFAULT
);
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_pulse;

    modport master (output btn_raw, input btn_level, input btn_pulse);
    modport slave  (input btn_raw, output btn_level, output btn_pulse);
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel -- 2-FF sync, stability counter, rise pulse.
// Optional auto-repeat pulses while held when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000
`endif
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int W = cnt_w(DB_CYCLES);
    localparam logic [W-1:0] DB_MAX = W'(DB_CYCLES - 1);

    logic         s1;
    logic         s;
    logic [W-1:0] cnt;
    logic         accept;
    logic         rise;
    logic         rpt;

    assign accept = (s != level) && (cnt == DB_MAX);
    assign rise   = accept && s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s     <= s1;
            cnt   <= (s == level || accept) ? '0 : cnt + 1'b1;
            level <= accept ? s : level;
            pulse <= rise || rpt;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW   = cnt_w(RMAX);

    logic [RW-1:0] rcnt;
    logic          rphase;
    logic [RW-1:0] rlim;

    // First wait is RPT_DELAY from the press pulse, later waits are RPT_PERIOD.
    assign rlim = rphase ? RW'(RPT_PERIOD - 1) : RW'(RPT_DELAY - 1);
    assign rpt  = level && !accept && (rcnt == rlim);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rcnt   <= '0;
            rphase <= 1'b0;
        end else if (!level || accept) begin
            rcnt   <= '0;
            rphase <= 1'b0;
        end else begin
            rcnt   <= (rcnt == rlim) ? '0 : rcnt + 1'b1;
            rphase <= rphase || (rcnt == rlim);
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent debounced buttons with level and press pulse.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat pulses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN      = N_BTN_DEFAULT,
    parameter int DB_CYCLES  = 1_000_000,
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    btn_conditioner_if.slave  bus
);
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] pulse;

    if (DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_cfg
        $error("btn_conditioner: DB_CYCLES, RPT_DELAY and RPT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES (DB_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            ,
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
`endif
        ) u_ch (
            .clk   (clk),
            .resetn(resetn),
            .raw   (bus.btn_raw[i]),
            .level (level[i]),
            .pulse (pulse[i])
        );
    end

    assign bus.btn_level = level;
    assign bus.btn_pulse = pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random stimulus checked against a window-based
// reference model (level accepted once the synced input differed for DB straight cycles).
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    btn_conditioner_if #(.N(N)) bus ();

    btn_conditioner #(
        .N_BTN     (N),
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] r1_m  = '0;
    logic [N-1:0] s_m   = '0;
    logic [N-1:0] lvl_m = '0;
    logic [N-1:0] pls_m = '0;
    bit           win   [N][DB];
    int           nfill [N];
    int           held  [N];

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < N; c++) begin
            if (!resetn) begin
                r1_m[c]  = 1'b0;
                s_m[c]   = 1'b0;
                lvl_m[c] = 1'b0;
                pls_m[c] = 1'b0;
                nfill[c] = 0;
                held[c]  = 0;
            end else begin
                bit so  = s_m[c];
                bit acc;
                bit p   = 1'b0;
                for (int k = DB - 1; k > 0; k--) win[c][k] = win[c][k-1];
                win[c][0] = so;
                if (nfill[c] < DB) nfill[c]++;
                acc = (nfill[c] == DB);
                for (int k = 0; k < DB; k++) if (win[c][k] == lvl_m[c]) acc = 1'b0;
                if (acc) begin
                    lvl_m[c] = so;
                    p        = so;
                    held[c]  = 0;
                end else if (lvl_m[c]) begin
                    held[c]++;
`ifdef BTN_AUTOREPEAT_EN
                    p = (held[c] == RD) || (held[c] > RD && (held[c] - RD) % RP == 0);
`endif
                end
                pls_m[c] = p;
                s_m[c]   = r1_m[c];
                r1_m[c]  = bus.btn_raw[c];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("level", bus.btn_level, lvl_m);
        chk("pulse", bus.btn_pulse, pls_m);
    endtask

    initial begin
        int npls;
        for (int c = 0; c < N; c++) begin
            nfill[c] = 0;
            held[c]  = 0;
        end
        bus.btn_raw = 5'b11111;
        resetn      = 1'b0;
        repeat (3) tick();
        chk("reset_level", bus.btn_level, 5'b00000);
        resetn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("rst_rel_early", bus.btn_level, 5'b00000);
            if (k == 6) begin
                chk("rst_rel_level", bus.btn_level, 5'b11111);
                chk("rst_rel_pulse", bus.btn_pulse, 5'b11111);
            end
            if (k == 7) chk("rst_rel_pulse_end", bus.btn_pulse, 5'b00000);
        end
        bus.btn_raw = '0;
        repeat (10) tick();

        npls = 0;
        bus.btn_raw = 5'b10000;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 6) chk("press_pulse", bus.btn_pulse, 5'b10000);
            npls += int'(bus.btn_pulse[4]);
        end
        bus.btn_raw = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) chk("release_hold", bus.btn_level, 5'b10000);
            if (k == 6) chk("release_fall", bus.btn_level, 5'b00000);
            npls += int'(bus.btn_pulse[4]);
        end
`ifdef BTN_AUTOREPEAT_EN
        chk("press_count", N'(npls), N'(5));
`else
        chk("press_count", N'(npls), N'(1));
`endif

        npls = 0;
        for (int i = 0; i < 4; i++) begin
            bus.btn_raw[0] = (i % 2 == 0);
            repeat (2) begin
                tick();
                npls += int'(bus.btn_pulse[0]);
            end
        end
        chk("bounce_none", N'(npls), N'(0));
        bus.btn_raw[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) chk("bounce_early", bus.btn_pulse, 5'b00000);
            if (k == 6) chk("bounce_pulse", bus.btn_pulse, 5'b00001);
        end
        bus.btn_raw = '0;
        repeat (12) tick();

        bus.btn_raw = 5'b01010;
        repeat (6) tick();
        chk("simul_level", bus.btn_level, 5'b01010);
        chk("simul_pulse", bus.btn_pulse, 5'b01010);
        bus.btn_raw = '0;
        repeat (10) tick();

        bus.btn_raw = 5'b00100;
        repeat (4) tick();
        resetn = 1'b0;
        repeat (2) tick();
        chk("mid_rst_level", bus.btn_level, 5'b00000);
        resetn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) chk("mid_rst_early", bus.btn_pulse, 5'b00000);
            if (k == 6) chk("mid_rst_pulse", bus.btn_pulse, 5'b00100);
        end
        bus.btn_raw = '0;
        repeat (10) tick();

        npls = 0;
        bus.btn_raw = 5'b10000;
        for (int k = 0; k < 40; k++) begin
            if (k == 30) bus.btn_raw = '0;
            tick();
            npls += int'(bus.btn_pulse[4]);
        end
`ifdef BTN_AUTOREPEAT_EN
        chk("hold_count", N'(npls), N'(8));
`else
        chk("hold_count", N'(npls), N'(1));
`endif

        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(5) == 0) bus.btn_raw[c] = ~bus.btn_raw[c];
            resetn = ($urandom_range(149) != 0);
            tick();
            resetn = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
